emit_sched: RTL
===============

# emit_sched

Two-class output scheduler that drains a priority FIFO and a regular FIFO into one registered valid/ready output port. It sits between the per-class FIFOs and the router output link. It applies strict priority to the priority class, plus a compile-time anti-starvation guard that forces one regular flit through after a configurable run of priority flits.

## Interface
- DATA_WIDTH, 32, flit width in bits.
- STARVE_LIMIT, 4, maximum consecutive priority loads while regular is pending; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset. Asserting it clears all state immediately; deassertion is synchronous to clk externally.
- PriEmpty_i  input  1  priority FIFO empty flag.
- PriData_i  input  DATA_WIDTH  priority FIFO head. FIFO is first-word-fall-through, so the head is valid whenever PriEmpty_i=0.
- PriRead_o  output  1  pops the priority FIFO head this cycle.
- RegEmpty_i  input  1  regular FIFO empty flag.
- RegData_i  input  DATA_WIDTH  regular FIFO head, first-word-fall-through.
- RegRead_o  output  1  pops the regular FIFO head this cycle.
- Data_o  output  DATA_WIDTH  output flit register.
- Valid_o  output  1  output flit valid.
- Ready_i  input  1  downstream accepts the flit when Valid_o and Ready_i are both 1.
- SrcPri_o  output  1  class of the flit in the output register: 1 = priority, 0 = regular.

## Operation
- State:
  - Output register: Data_o, Valid_o, SrcPri_o.
  - Starvation counter StarveCnt, width $clog2(STARVE_LIMIT+1).
- Load enable: Load = (~Valid_o | Ready_i) & (~PriEmpty_i | ~RegEmpty_i).
- Source select when Load=1:
  - Only one FIFO non-empty: pick that FIFO.
  - Both non-empty: pick regular if StarveCnt == STARVE_LIMIT (guard compiled in); otherwise pick priority.
- Read strobes:
  - PriRead_o = Load & select_pri.
  - RegRead_o = Load & ~select_pri.
  - Both are combinational and never high together.
- On Load: Data_o <= selected head, SrcPri_o <= select_pri, Valid_o <= 1.
- If (Valid_o & Ready_i & ~Load): Valid_o <= 0. Data_o and SrcPri_o hold their values.
- StarveCnt update, only on Load:
  - Regular selected: StarveCnt <= 0.
  - Priority selected and RegEmpty_i=1: StarveCnt <= 0.
  - Priority selected and RegEmpty_i=0: StarveCnt <= StarveCnt+1, saturating at STARVE_LIMIT.
  - No Load: StarveCnt holds.
- Reset values: Valid_o=0, Data_o=0, SrcPri_o=0, StarveCnt=0. PriRead_o and RegRead_o are forced to 0 while rst=1.
- FIFO contract: reading an empty FIFO never occurs. The bench asserts that PriRead_o implies ~PriEmpty_i, and RegRead_o implies ~RegEmpty_i.

## Timing
- Latency: a flit at the FIFO head in cycle N with the output register free appears on Data_o/Valid_o in cycle N+1.
- Throughput: one flit per cycle while Ready_i=1 and either FIFO is non-empty. Pop and accept happen in the same cycle with no bubble.
- Backpressure: while Valid_o=1 and Ready_i=0:
  - Data_o, Valid_o and SrcPri_o are stable.
  - No FIFO is read and StarveCnt holds.
- Simultaneous events: a flit arriving in a FIFO in the same cycle as the output is accepted is loaded only if the FIFO empty flag is already low that cycle. Empty flags are sampled combinationally; no lookahead.
- Reset mid-transfer: a held flit is discarded. Valid_o drops asynchronously, and FIFO contents are untouched.

## Configuration
- EMIT_STARVE_GUARD_EN:
  - Defined: starvation guard and StarveCnt are present as described above.
  - Undefined: StarveCnt is removed and selection is strict priority. Regular is picked only when PriEmpty_i=1, and STARVE_LIMIT is ignored.

## Test plan
- Reset then idle, both FIFOs empty: Valid_o=0, Data_o=0, SrcPri_o=0, and no read strobe for 20 cycles.
- Priority FIFO holds 0xA1,0xA2,0xA3, regular empty, Ready_i=1: Data_o gives 0xA1,0xA2,0xA3 in consecutive cycles with SrcPri_o=1, starting one cycle after the first PriRead_o.
- Guard on, STARVE_LIMIT=4, both FIFOs continuously non-empty, Ready_i=1: the output class sequence repeats P,P,P,P,R. RegRead_o pulses exactly every 5th cycle.
- Guard off, same stimulus as the previous scenario: RegRead_o never pulses until the priority FIFO drains. The first regular flit follows the last priority flit with no bubble.
- Valid_o=1 holding 0x55, Ready_i=0 for 6 cycles with both FIFOs non-empty: Data_o stays 0x55, no reads occur, and StarveCnt is unchanged. After Ready_i=1, the next flit appears the following cycle.
- Assert rst for one cycle while Valid_o=1: Valid_o=0 and Data_o=0 immediately, StarveCnt=0. After release, the first load is from priority if it is non-empty.

Source files
------------

// File: rtl/emit_sched.sv
`default_nettype none
// ============================================================================
// Module   : emit_sched
// Purpose  : Two-class output scheduler. Drains a priority FIFO and a regular
//            FIFO (both first-word-fall-through) into one registered
//            valid/ready output. Strict priority, with an optional
//            anti-starvation guard that forces one regular flit through
//            after STARVE_LIMIT consecutive priority loads while regular
//            traffic is waiting.
// Config   : `define EMIT_STARVE_GUARD_EN to build the starvation guard;
//            without it selection is strict priority and STARVE_LIMIT is
//            only range-checked.
// Revision : 1.0 - initial release
// ============================================================================
module emit_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PriEmpty_i,
  input  logic [DATA_WIDTH-1:0] PriData_i,
  output logic                  PriRead_o,
  input  logic                  RegEmpty_i,
  input  logic [DATA_WIDTH-1:0] RegData_i,
  output logic                  RegRead_o,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic                  SrcPri_o
);

  // Catch an out-of-range limit at elaboration time.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
    $error("emit_sched: STARVE_LIMIT must lie in 1..255");
  end

  logic load;        // output register takes a new flit this cycle
  logic select_pri;  // which FIFO feeds the register when loading
  logic starved;     // regular class has waited its maximum run

`ifdef EMIT_STARVE_GUARD_EN
  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign starved = (starve_cnt == CNT_MAX);

  // Count consecutive priority loads that bypassed a waiting regular flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (load) begin
      if (!select_pri || RegEmpty_i) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Load/select decision; read strobes are held low during reset.
  always_comb begin
    load       = 1'b0;
    select_pri = 1'b0;
    PriRead_o  = 1'b0;
    RegRead_o  = 1'b0;
    // Priority wins unless it is empty or regular has been starved.
    select_pri = !PriEmpty_i && (RegEmpty_i || !starved);
    load       = !rst && (!Valid_o || Ready_i) && (!PriEmpty_i || !RegEmpty_i);
    PriRead_o  = load && select_pri;
    RegRead_o  = load && !select_pri;
  end

  // Output register: capture the chosen head, or go idle once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Valid_o  <= 1'b0;
      Data_o   <= '0;
      SrcPri_o <= 1'b0;
    end else if (load) begin
      Valid_o  <= 1'b1;
      Data_o   <= select_pri ? PriData_i : RegData_i;
      SrcPri_o <= select_pri;
    end else if (Valid_o && Ready_i) begin
      Valid_o  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
